// File: rtl/mm_pkg.sv
// Shared state type and width helper for the matrix-multiply result reader.
package mm_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} mm_rd_state_t;

  function automatic int res_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mm_row_buf.sv
// One buffered result row (N banks wide), emitted one column per handshake.
module mm_row_buf
  import mm_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  RW = res_width(4, 2),
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [N*RW-1:0] load_data,
  input  logic            load_last,
  input  logic            ready,
  output logic            valid,
  output logic [RW-1:0]   data,
  output logic [CW-1:0]   col,
  output logic            last_col,
  output logic            last
);

  logic [N*RW-1:0] row_q, row_d;
  logic            full_q, full_d;
  logic [CW-1:0]   col_q, col_d;
  logic            last_row_q, last_row_d;

  always_comb begin
    row_d      = row_q;
    full_d     = full_q;
    col_d      = col_q;
    last_row_d = last_row_q;
    if (load) begin
      row_d      = load_data;
      full_d     = 1'b1;
      col_d      = '0;
      last_row_d = load_last;
    end else if (full_q && ready) begin
      if (col_q == CW'(N - 1)) begin
        full_d = 1'b0;
        col_d  = '0;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q      <= '0;
      full_q     <= 1'b0;
      col_q      <= '0;
      last_row_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      full_q     <= full_d;
      col_q      <= col_d;
      last_row_q <= last_row_d;
    end
  end

  assign valid    = full_q;
  assign data     = row_q[col_q*RW +: RW];
  assign col      = col_q;
  assign last_col = (col_q == CW'(N - 1));
  assign last     = full_q && last_col && last_row_q;

endmodule

// File: rtl/mm_result_reader.sv
// Drains N result banks address by address onto one row-major valid/ready stream.
// Define MM_RD_PREFETCH_EN for a second row buffer that makes the stream gap-free.
module mm_result_reader
  import mm_pkg::*;
#(
  parameter int  N          = 4,
  parameter int  DW         = 2,
  parameter int  BRAM_DEPTH = 32,
  localparam int RW         = res_width(N, DW),
  localparam int AW         = $clog2(BRAM_DEPTH),
  localparam int CW         = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     num_rows,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [N*RW-1:0] rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [RW-1:0]   m_data,
  output logic            m_last,
  output logic [CW-1:0]   m_col,
  output logic            busy,
  output logic            done
);

  mm_rd_state_t  state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW:0]   rows_q, rows_d;
  logic [AW:0]   issued_q, issued_d;
  logic          pend_q;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_last, beat, row_end, next_row, prefetch;

  // The row landing now is the final one when the address just read is num_rows-1.
  assign load_last = ({1'b0, rd_addr_q} == rows_q - (AW+1)'(1));

`ifdef MM_RD_PREFETCH_EN
  logic [1:0]    buf_valid, buf_last_col, buf_last;
  logic [RW-1:0] buf_data [2];
  logic [CW-1:0] buf_col [2];
  logic          load_sel_q, load_sel_d, out_sel_q, out_sel_d;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    mm_row_buf #(.N(N), .RW(RW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (pend_q && (load_sel_q == 1'(i))),
      .load_data (rd_data),
      .load_last (load_last),
      .ready     (m_ready && (out_sel_q == 1'(i))),
      .valid     (buf_valid[i]),
      .data      (buf_data[i]),
      .col       (buf_col[i]),
      .last_col  (buf_last_col[i]),
      .last      (buf_last[i])
    );
  end

  assign m_valid  = buf_valid[out_sel_q];
  assign m_data   = buf_data[out_sel_q];
  assign m_col    = buf_col[out_sel_q];
  assign m_last   = buf_last[out_sel_q];
  assign beat     = m_valid && m_ready;
  assign row_end  = beat && buf_last_col[out_sel_q];
  assign next_row = 1'b0;
  // Only one read may be in flight, and only into an empty spare buffer.
  assign prefetch = (state_q == SEND) && !buf_valid[load_sel_q] && !rd_en_q && !pend_q &&
                    (issued_q != rows_q);

  always_comb begin
    load_sel_d = load_sel_q ^ pend_q;
    out_sel_d  = out_sel_q ^ row_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
    end else begin
      load_sel_q <= load_sel_d;
      out_sel_q  <= out_sel_d;
    end
  end
`else
  logic buf_last_col;

  mm_row_buf #(.N(N), .RW(RW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (pend_q),
    .load_data (rd_data),
    .load_last (load_last),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .col       (m_col),
    .last_col  (buf_last_col),
    .last      (m_last)
  );

  assign beat     = m_valid && m_ready;
  assign row_end  = beat && buf_last_col;
  assign next_row = row_end && (issued_q != rows_q);
  assign prefetch = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rows_d    = rows_q;
    issued_d  = issued_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rows_d    = num_rows;
          rd_addr_d = '0;
          issued_d  = '0;
          if (num_rows == '0) begin
            state_d = DONE;
          end else begin
            state_d  = READ;
            rd_en_d  = 1'b1;
            issued_d = (AW+1)'(1);
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: state_d = SEND;
      SEND: begin
        if (beat && m_last) begin
          state_d = DONE;
        end else if (next_row) begin
          state_d = READ;
        end
        if (next_row || prefetch) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
          issued_d  = issued_q + (AW+1)'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rows_q    <= '0;
      issued_q  <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rows_q    <= rows_d;
      issued_q  <= issued_d;
      pend_q    <= rd_en_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mm_result_reader.sv
// Directed self-checking bench for mm_result_reader; honours MM_RD_PREFETCH_EN for gap timing.
module tb_mm_result_reader;

  localparam int N          = 4;
  localparam int DW         = 2;
  localparam int BRAM_DEPTH = 32;
  localparam int RW         = 2 * DW + $clog2(N);
  localparam int AW         = $clog2(BRAM_DEPTH);
  localparam int CW         = $clog2(N);
`ifdef MM_RD_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            m_ready = 1'b0;
  logic [AW:0]     num_rows = '0;
  logic [N*RW-1:0] rd_data = '0;
  logic            rd_en, m_valid, m_last, busy, done;
  logic [AW-1:0]   rd_addr;
  logic [RW-1:0]   m_data;
  logic [CW-1:0]   m_col;

  int checks = 0;
  int fails  = 0;

  int            cur_c, beat_n, rd_cnt, first_rd_cyc, max_addr, done_cnt, done_cyc;
  int            busy_cnt, busy_first, first_valid, stall_err;
  logic [AW-1:0] first_rd_addr;
  logic [RW-1:0] bd [256];
  logic [CW-1:0] bc [256];
  logic          bl [256];
  int            bcyc [256];
  logic          prev_stall, p_last;
  logic [RW-1:0] p_data;
  logic [CW-1:0] p_col;

  mm_result_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rows (num_rows),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_col    (m_col),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Result RAMs: bank j at address a holds a*N+j (kept to RW bits), one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int j = 0; j < N; j++) rd_data[j*RW +: RW] <= RW'(int'(rd_addr) * N + j);
    end
  end

  function automatic int exp_cyc(input int i);
    return 3 + i + GAP * (i / N);
  endfunction

  function automatic logic [RW-1:0] exp_val(input int i);
    return RW'((i / N) * N + (i % N));
  endfunction

  task automatic clear_mon();
    beat_n = 0; rd_cnt = 0; first_rd_cyc = -1; max_addr = -1; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; first_valid = -1; stall_err = 0; prev_stall = 1'b0;
    first_rd_addr = '1;
  endtask

  // Called at the falling edge; cur_c is the cycle index relative to the start cycle.
  task automatic sample();
    if (rd_en) begin
      if (rd_cnt == 0) begin first_rd_cyc = cur_c; first_rd_addr = rd_addr; end
      rd_cnt++;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = cur_c; end
    if (done) begin done_cnt++; done_cyc = cur_c; end
    if (m_valid && first_valid < 0) first_valid = cur_c;
    if (prev_stall && (m_valid !== 1'b1 || m_data !== p_data || m_col !== p_col || m_last !== p_last))
      stall_err++;
    if (m_valid && m_ready && beat_n < 256) begin
      bd[beat_n] = m_data; bc[beat_n] = m_col; bl[beat_n] = m_last; bcyc[beat_n] = cur_c;
      beat_n++;
    end
    prev_stall = m_valid && !m_ready;
    p_data = m_data; p_col = m_col; p_last = m_last;
  endtask

  task automatic run_drain(input int rows, input bit toggle, input int budget);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; num_rows = (AW+1)'(rows); m_ready = 1'b1;
    cur_c = 0;
    @(negedge clk); sample();
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      m_ready = toggle ? ((k % 2) == 0) : 1'b1;
      @(negedge clk);
      cur_c = k;
      sample();
      if (done_cnt > 0 && k >= done_cyc + 3) break;
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (rd_addr !== '0) begin fails++; $display("[TB] FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    checks++; if (m_col !== '0) begin fails++; $display("[TB] FAIL reset_m_col: got %0d want 0", m_col); end
    checks++; if (m_data !== '0) begin fails++; $display("[TB] FAIL reset_m_data: got %0d want 0", m_data); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    run_drain(2, 1'b0, 60);
    checks++; if (beat_n !== 8) begin fails++; $display("[TB] FAIL t1_beats: got %0d want 8", beat_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bd[i] !== exp_val(i)) begin fails++; $display("[TB] FAIL t1_data[%0d]: got %0d want %0d", i, bd[i], exp_val(i)); end
      checks++; if (bc[i] !== CW'(i % N)) begin fails++; $display("[TB] FAIL t1_col[%0d]: got %0d want %0d", i, bc[i], i % N); end
      checks++; if (bl[i] !== (i == 7)) begin fails++; $display("[TB] FAIL t1_last[%0d]: got %b want %b", i, bl[i], i == 7); end
      checks++; if (bcyc[i] !== exp_cyc(i)) begin fails++; $display("[TB] FAIL t1_cyc[%0d]: got %0d want %0d", i, bcyc[i], exp_cyc(i)); end
    end
    checks++; if (first_rd_cyc !== 1) begin fails++; $display("[TB] FAIL t1_rd_cyc: got %0d want 1", first_rd_cyc); end
    checks++; if (first_rd_addr !== '0) begin fails++; $display("[TB] FAIL t1_rd_addr: got %0d want 0", first_rd_addr); end
    checks++; if (rd_cnt !== 2) begin fails++; $display("[TB] FAIL t1_rd_cnt: got %0d want 2", rd_cnt); end
    checks++; if (first_valid !== 3) begin fails++; $display("[TB] FAIL t1_first_valid: got %0d want 3", first_valid); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL t1_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== exp_cyc(7) + 1) begin fails++; $display("[TB] FAIL t1_done_cyc: got %0d want %0d", done_cyc, exp_cyc(7) + 1); end
    checks++; if (busy_first !== 1) begin fails++; $display("[TB] FAIL t1_busy_first: got %0d want 1", busy_first); end
    checks++; if (busy_cnt !== exp_cyc(7) + 1) begin fails++; $display("[TB] FAIL t1_busy_cnt: got %0d want %0d", busy_cnt, exp_cyc(7) + 1); end
  endtask

  task automatic test_backpressure();
    run_drain(2, 1'b1, 80);
    checks++; if (beat_n !== 8) begin fails++; $display("[TB] FAIL t2_beats: got %0d want 8", beat_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bd[i] !== exp_val(i)) begin fails++; $display("[TB] FAIL t2_data[%0d]: got %0d want %0d", i, bd[i], exp_val(i)); end
      checks++; if (bl[i] !== (i == 7)) begin fails++; $display("[TB] FAIL t2_last[%0d]: got %b want %b", i, bl[i], i == 7); end
    end
    checks++; if (stall_err !== 0) begin fails++; $display("[TB] FAIL t2_stall_stable: got %0d changes want 0", stall_err); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL t2_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_rows();
    run_drain(0, 1'b0, 20);
    checks++; if (rd_cnt !== 0) begin fails++; $display("[TB] FAIL t3_rd_cnt: got %0d want 0", rd_cnt); end
    checks++; if (first_valid !== -1) begin fails++; $display("[TB] FAIL t3_valid_seen: got cycle %0d want none", first_valid); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL t3_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== 1) begin fails++; $display("[TB] FAIL t3_done_cyc: got %0d want 1", done_cyc); end
    checks++; if (busy_cnt !== 1) begin fails++; $display("[TB] FAIL t3_busy_cnt: got %0d want 1", busy_cnt); end
    checks++; if (busy_first !== 1) begin fails++; $display("[TB] FAIL t3_busy_first: got %0d want 1", busy_first); end
  endtask

  task automatic test_full_depth();
    int lasts;
    run_drain(BRAM_DEPTH, 1'b0, 300);
    lasts = 0;
    checks++; if (beat_n !== 128) begin fails++; $display("[TB] FAIL t4_beats: got %0d want 128", beat_n); end
    for (int i = 0; i < 128 && i < beat_n; i++) begin
      checks++; if (bd[i] !== exp_val(i)) begin fails++; $display("[TB] FAIL t4_data[%0d]: got %0d want %0d", i, bd[i], exp_val(i)); end
      if (bl[i] === 1'b1) lasts++;
    end
    checks++; if (bl[127] !== 1'b1 || lasts !== 1) begin fails++; $display("[TB] FAIL t4_last: got last127=%b count=%0d want 1/1", bl[127], lasts); end
    checks++; if (max_addr !== 31) begin fails++; $display("[TB] FAIL t4_max_addr: got %0d want 31", max_addr); end
    checks++; if (rd_cnt !== 32) begin fails++; $display("[TB] FAIL t4_rd_cnt: got %0d want 32", rd_cnt); end
    // 127 = 31*4+3 does not fit the 6-bit result width, so the bank holds 127 mod 64.
    checks++; if (bd[127] !== RW'(127)) begin fails++; $display("[TB] FAIL t4_final_value: got %0d want %0d", bd[127], RW'(127)); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL t4_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int extra_done, extra_busy;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; num_rows = (AW+1)'(4); m_ready = 1'b1;
    cur_c = 0;
    @(negedge clk); sample();
    for (int k = 1; k <= 60 && beat_n < 6; k++) begin
      @(posedge clk); #1;
      start    = (k == 5);
      num_rows = (k == 5) ? (AW+1)'(1) : (AW+1)'(4);
      @(negedge clk);
      cur_c = k;
      sample();
    end
    start = 1'b0;
    checks++; if (beat_n !== 6) begin fails++; $display("[TB] FAIL t5_pre_beats: got %0d want 6", beat_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (bd[i] !== exp_val(i)) begin fails++; $display("[TB] FAIL t5_data[%0d]: got %0d want %0d", i, bd[i], exp_val(i)); end
    end
    checks++; if (rd_cnt !== 2) begin fails++; $display("[TB] FAIL t5_restart_ignored: got %0d reads want 2", rd_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL t5_abort_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL t5_abort_busy: got %b want 0", busy); end
    extra_done = (done === 1'b1) ? 1 : 0;
    extra_busy = (busy === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++; if (extra_done !== 0) begin fails++; $display("[TB] FAIL t5_no_done: got %0d pulses want 0", extra_done); end
    checks++; if (extra_busy !== 0) begin fails++; $display("[TB] FAIL t5_idle_busy: got %0d cycles want 0", extra_busy); end
    run_drain(1, 1'b0, 40);
    checks++; if (beat_n !== 4) begin fails++; $display("[TB] FAIL t5_fresh_beats: got %0d want 4", beat_n); end
    checks++; if (first_rd_addr !== '0) begin fails++; $display("[TB] FAIL t5_fresh_addr: got %0d want 0", first_rd_addr); end
    checks++; if (bd[0] !== '0) begin fails++; $display("[TB] FAIL t5_fresh_value: got %0d want 0", bd[0]); end
    checks++; if (bl[3] !== 1'b1) begin fails++; $display("[TB] FAIL t5_fresh_last: got %b want 1", bl[3]); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL t5_fresh_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    run_drain(4, 1'b0, 80);
    checks++; if (beat_n !== 16) begin fails++; $display("[TB] FAIL t6_beats: got %0d want 16", beat_n); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bcyc[i] !== exp_cyc(i)) begin fails++; $display("[TB] FAIL t6_cyc[%0d]: got %0d want %0d", i, bcyc[i], exp_cyc(i)); end
      checks++; if (bd[i] !== exp_val(i)) begin fails++; $display("[TB] FAIL t6_data[%0d]: got %0d want %0d", i, bd[i], exp_val(i)); end
    end
    checks++; if (max_addr !== 3) begin fails++; $display("[TB] FAIL t6_max_addr: got %0d want 3", max_addr); end
    checks++; if (done_cyc !== exp_cyc(15) + 1) begin fails++; $display("[TB] FAIL t6_done_cyc: got %0d want %0d", done_cyc, exp_cyc(15) + 1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_rows();
    test_full_depth();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
